// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Purpose : Shared constants for the 2-way set-associative cache controller:
//           address field positions, line/word geometry, FSM state encoding
//           and a small word-select helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Address layout: [31:9] tag, [8:4] set index, [3:2] word, [1:0] byte
  localparam int OFFSET_W = 4;
  localparam int WORD_LSB = 2;
  localparam int WORD_W   = 2;

  // Controller states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_WB     = 2'd2;
  localparam logic [1:0] ST_REFILL = 2'd3;

  // One-hot word enable for a 4-word line
  function automatic logic [3:0] word_onehot(input logic [WORD_W-1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_meta.sv
`default_nettype none
// ============================================================================
// Module  : cache_meta
// Purpose : Valid, dirty and LRU state for every set of a 2-way cache.
//           All bits clear asynchronously. One set is read and updated at a
//           time, selected by idx.
// Ports   : clk, rst_n          - clock, async active-low reset
//           idx                 - set index for read and update
//           valid, dirty        - per-way bits of the indexed set
//           lru                 - LRU way of the indexed set
//           upd_way             - way affected by set/clear strobes
//           set_valid           - mark upd_way valid
//           set_dirty/clr_dirty - mark upd_way dirty/clean (set wins)
//           lru_we, lru_val     - write LRU bit of the indexed set
// Revision: 1.0 - initial release
// ============================================================================
module cache_meta #(
  parameter int SETS  = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  output logic [1:0]       valid,
  output logic [1:0]       dirty,
  output logic             lru,
  input  logic             upd_way,
  input  logic             set_valid,
  input  logic             set_dirty,
  input  logic             clr_dirty,
  input  logic             lru_we,
  input  logic             lru_val
);

  logic [1:0] valid_q [SETS];
  logic [1:0] dirty_q [SETS];
  logic       lru_q   [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      if (set_valid) valid_q[idx][upd_way] <= 1'b1;
      if (set_dirty)      dirty_q[idx][upd_way] <= 1'b1;
      else if (clr_dirty) dirty_q[idx][upd_way] <= 1'b0;
      if (lru_we) lru_q[idx] <= lru_val;
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign lru   = lru_q[idx];

endmodule
`default_nettype wire

// File: rtl/cache_2way_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cache_2way_ctrl
// Purpose : Write-back, write-allocate, LRU controller for a 2-way,
//           32-set, 16-byte-line cache. Drives an external tag/data array,
//           serves CPU loads/stores, and moves whole lines over a memory bus.
// Ports   : clk, rst_n          - clock, async active-low reset
//           cpu_req_*           - CPU request (accepted only while ready)
//           cpu_resp_valid/rdata- one-cycle response pulse and load data
//           mem_req/we/addr/wdata, mem_rdata/ack - line-wide memory bus
//           arr_*               - tag/data array write controls and the
//                                 combinational per-way read results
// Revision: 1.0 - initial release
// ============================================================================
module cache_2way_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH       = 5,
  parameter int TAG_BITS         = 23,
  parameter int WHOLE_DATA_WIDTH = 128,
  parameter int BANK_DATA_WIDTH  = 32,
  parameter int DATA_WORD_NUM    = 4,
  parameter int DATA_BYTE_NUM    = 4,
  parameter int CACHE_WAY_NUM    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic                        cpu_req_we,
  input  logic [31:0]                 cpu_req_addr,
  input  logic [BANK_DATA_WIDTH-1:0]  cpu_req_wdata,
  input  logic [DATA_BYTE_NUM-1:0]    cpu_req_byte_en,
  output logic                        cpu_resp_valid,
  output logic [BANK_DATA_WIDTH-1:0]  cpu_resp_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [WHOLE_DATA_WIDTH-1:0] mem_wdata,
  input  logic [WHOLE_DATA_WIDTH-1:0] mem_rdata,
  input  logic                        mem_ack,
  output logic                        arr_wr_en,
  output logic                        arr_wr_tag_en,
  output logic [ADDR_WIDTH-1:0]       arr_addr,
  output logic [CACHE_WAY_NUM-1:0]    arr_way_select,
  output logic [WHOLE_DATA_WIDTH-1:0] arr_wr_data,
  output logic [TAG_BITS-1:0]         arr_wr_tag,
  output logic [DATA_WORD_NUM-1:0]    arr_wr_word_en,
  output logic [DATA_BYTE_NUM-1:0]    arr_wr_byte_en,
  input  logic [TAG_BITS-1:0]         arr_tag_way0,
  input  logic [TAG_BITS-1:0]         arr_tag_way1,
  input  logic [WHOLE_DATA_WIDTH-1:0] arr_rd_data_way0,
  input  logic [WHOLE_DATA_WIDTH-1:0] arr_rd_data_way1
);

  localparam int IDX_LSB = OFFSET_W;
  localparam int TAG_LSB = OFFSET_W + ADDR_WIDTH;

  logic [1:0]                 state;
  logic                       req_we;
  logic [31:WORD_LSB]         req_addr;
  logic [BANK_DATA_WIDTH-1:0] req_wdata;
  logic [DATA_BYTE_NUM-1:0]   req_be;
  logic                       victim;

  // Byte offset bits never matter to a word-granular cache
  logic unused_byte_ofs;
  assign unused_byte_ofs = ^cpu_req_addr[WORD_LSB-1:0];

  logic [ADDR_WIDTH-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [WORD_W-1:0]     req_word;
  assign req_idx  = req_addr[TAG_LSB-1:IDX_LSB];
  assign req_tag  = req_addr[31:TAG_LSB];
  assign req_word = req_addr[IDX_LSB-1:WORD_LSB];

  // Metadata
  logic [1:0] valid, dirty;
  logic       lru;
  logic       upd_way, set_valid, set_dirty, clr_dirty, lru_we;

  cache_meta #(
    .SETS  (1 << ADDR_WIDTH),
    .IDX_W (ADDR_WIDTH)
  ) u_meta (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (req_idx),
    .valid     (valid),
    .dirty     (dirty),
    .lru       (lru),
    .upd_way   (upd_way),
    .set_valid (set_valid),
    .set_dirty (set_dirty),
    .clr_dirty (clr_dirty),
    .lru_we    (lru_we),
    .lru_val   (~upd_way)
  );

  // Lookup
  logic                        hit0, hit1, hit, hit_way;
  logic [WHOLE_DATA_WIDTH-1:0] hit_line;
  logic [BANK_DATA_WIDTH-1:0]  hit_word;
  assign hit0     = valid[0] & (arr_tag_way0 == req_tag);
  assign hit1     = valid[1] & (arr_tag_way1 == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = hit1 ? arr_rd_data_way1 : arr_rd_data_way0;
  assign hit_word = hit_line[req_word*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];

  // Victim: first invalid way (way0 first), otherwise the LRU way
  logic                        victim_next, victim_dirty;
  logic [TAG_BITS-1:0]         victim_tag;
  logic [WHOLE_DATA_WIDTH-1:0] victim_line;
  assign victim_next  = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);
  assign victim_dirty = valid[victim_next] & dirty[victim_next];
  assign victim_tag   = victim_next ? arr_tag_way1 : arr_tag_way0;
  assign victim_line  = victim_next ? arr_rd_data_way1 : arr_rd_data_way0;

  logic lookup_hit, store_fire, refill_fire;
  assign lookup_hit  = (state == ST_LOOKUP) && hit;
  assign store_fire  = lookup_hit && req_we;
  // mem_req is checked so a stale ack during the post-writeback gap is inert
  assign refill_fire = (state == ST_REFILL) && mem_req && mem_ack;

  assign upd_way   = refill_fire ? victim : hit_way;
  assign set_valid = refill_fire;
  assign clr_dirty = refill_fire;
  assign set_dirty = store_fire;
  assign lru_we    = lookup_hit | refill_fire;

  assign cpu_req_ready = (state == ST_IDLE);
  assign arr_addr      = req_idx;

  always_comb begin
    arr_wr_en      = store_fire | refill_fire;
    arr_wr_tag_en  = refill_fire;
    arr_way_select = '0;
    arr_wr_data    = '0;
    arr_wr_tag     = '0;
    arr_wr_word_en = '0;
    arr_wr_byte_en = '0;
    if (refill_fire) begin
      arr_way_select = victim ? 2'b10 : 2'b01;
      arr_wr_data    = mem_rdata;
      arr_wr_tag     = req_tag;
      arr_wr_word_en = '1;
      arr_wr_byte_en = '1;
    end else if (store_fire) begin
      arr_way_select = hit_way ? 2'b10 : 2'b01;
      arr_wr_data    = {DATA_WORD_NUM{req_wdata}};
      arr_wr_word_en = word_onehot(req_word);
      arr_wr_byte_en = req_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_be         <= '0;
      victim         <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            req_we    <= cpu_req_we;
            req_addr  <= cpu_req_addr[31:WORD_LSB];
            req_wdata <= cpu_req_wdata;
            req_be    <= cpu_req_byte_en;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            cpu_resp_valid <= 1'b1;
            cpu_resp_rdata <= req_we ? '0 : hit_word;
            state          <= ST_IDLE;
          end else begin
            victim  <= victim_next;
            mem_req <= 1'b1;
            if (victim_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= {victim_tag, req_idx, {OFFSET_W{1'b0}}};
              mem_wdata <= victim_line;
              state     <= ST_WB;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
              mem_wdata <= '0;
              state     <= ST_REFILL;
            end
          end
        end
        ST_WB: begin
          // Drop mem_req for one cycle between the two transactions
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
            mem_wdata <= '0;
            state     <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_LOOKUP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
